// File: rtl/dtc_ddl_rdo_arbiter.sv
// Purpose: drains one DTC partition's channel RAMs into the DDL sender, one header per channel, end-of-event on the last word.
// Latency: header reaches ddl_data_o 1 cycle after HDR; a payload word 2 cycles after its RAM read issues; 1 word/cycle sustained.
// Backpressure: ddl_xoff_i stalls a 4-entry skid buffer; RAM reads issue only with >=2 free slots, so nothing is dropped.
module dtc_ddl_rdo_arbiter #(
    parameter int          NCH     = 20,
    parameter int          AW      = 10,
    parameter int          DW      = 33,
    parameter logic [15:0] HDR_TAG = 16'hDC5A
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              evt_rdy_i,
    input  logic [NCH-1:0]    dtc_event_rdy_i,
    output logic [NCH-1:0]    ram_enb_o,
    output logic [AW-1:0]     ram_addrb_o,
    input  logic [NCH*DW-1:0] ram_doutb_i,
    output logic              ram_read_confirm_o,
    input  logic              ddl_xoff_i,
    output logic [31:0]       ddl_data_o,
    output logic              ddl_valid_o,
    output logic              ddl_eoe_o,
    output logic              trunc_err_o
);
    localparam int             CW  = 5;
    localparam int             SD  = 4;
    localparam logic [NCH-1:0] ONE = NCH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_HDR, S_READ, S_DRAIN, S_CONFIRM
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ch_q;
    logic [NCH-1:0]  pend_q;
    logic [AW-1:0]   addr_q;
    logic            inflt_q;   // a read issued last cycle returns data this cycle
    logic            stop_q;    // last legal address issued; no further reads for this channel
    logic            trunc_q;
    logic [2:0]      cnt_q, cnt_d;
    logic [32:0]     skid_q [SD];
    logic [32:0]     skid_d [SD];

    logic [DW-1:0]   ret_dat;
    logic            ret_vld, ret_last, more, issue, push, pop;
    logic [32:0]     push_w;
    logic [NCH-1:0]  pend_rest;

    function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = NCH-1; i >= 0; i--)
            if (v[i]) r = CW'(i);
        return r;
    endfunction

    // Read-side decode: returned word, end-of-channel detection and read issue gating.
    always_comb begin
        ret_dat   = ram_doutb_i[int'(ch_q)*DW +: DW];
        pend_rest = pend_q & ~(ONE << ch_q);
        more      = |pend_rest;
        ret_vld   = (state_q == S_READ) && inflt_q;
        ret_last  = ret_vld && (ret_dat[DW-1] || stop_q);
        // Never read past an end flag: the returning word is checked in the same cycle.
        issue     = (state_q == S_READ) && !stop_q && !(ret_vld && ret_dat[DW-1])
                    && (cnt_q <= 3'd2);
        ram_enb_o = issue ? (ONE << ch_q) : '0;
    end

    // Word to push into the skid buffer this cycle: headers and returned payloads.
    always_comb begin
        push   = 1'b0;
        push_w = '0;
        case (state_q)
            S_SCAN: if (dtc_event_rdy_i == '0) begin
                push   = 1'b1;
                push_w = {1'b1, HDR_TAG, 11'd0, 5'h1F};
            end
            S_HDR: if (cnt_q != 3'(SD)) begin
                push   = 1'b1;
                push_w = {1'b0, HDR_TAG, 11'd0, ch_q};
            end
            S_READ: if (ret_vld) begin
                push   = 1'b1;
                push_w = {ret_last && !more, ret_dat[31:0]};
            end
            default: ;
        endcase
    end

    // Skid buffer next state: entry 0 is the head; pop shifts down, push appends behind the survivors.
    always_comb begin
        pop    = (cnt_q != 3'd0) && !ddl_xoff_i;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (pop) begin
            for (int i = 0; i < SD-1; i++) skid_d[i] = skid_q[i+1];
            skid_d[SD-1] = '0;
            cnt_d        = cnt_q - 3'd1;
        end
        if (push) begin
            skid_d[cnt_d[1:0]] = push_w;
            cnt_d              = cnt_d + 3'd1;
        end
    end

    // Sequencer: scan, per-channel header and read loop, drain, confirm.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            inflt_q <= 1'b0;
            stop_q  <= 1'b0;
            trunc_q <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < SD; i++) skid_q[i] <= '0;
        end else begin
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
            inflt_q <= issue;
            if (issue) begin
                addr_q <= addr_q + 1'b1;
                if (addr_q == '1) stop_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (evt_rdy_i) state_q <= S_SCAN;
                S_SCAN: begin
                    pend_q  <= dtc_event_rdy_i;
                    ch_q    <= lowest(dtc_event_rdy_i);
                    state_q <= (|dtc_event_rdy_i) ? S_HDR : S_DRAIN;
                end
                S_HDR: if (cnt_q != 3'(SD)) begin
                    addr_q  <= '0;
                    stop_q  <= 1'b0;
                    state_q <= S_READ;
                end
                S_READ: begin
                    if (ret_vld && stop_q && !ret_dat[DW-1]) trunc_q <= 1'b1;
                    if (ret_last) begin
                        pend_q  <= pend_rest;
                        ch_q    <= lowest(pend_rest);
                        state_q <= more ? S_HDR : S_DRAIN;
                    end
                end
                S_DRAIN:   if (cnt_q == 3'd0) state_q <= S_CONFIRM;
                S_CONFIRM: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_addrb_o        = addr_q;
    assign ram_read_confirm_o = (state_q == S_CONFIRM);
    assign ddl_valid_o        = (cnt_q != 3'd0);
    assign ddl_data_o         = skid_q[0][31:0];
    assign ddl_eoe_o          = skid_q[0][32];
    assign trunc_err_o        = trunc_q;

endmodule

// File: tb/tb_dtc_ddl_rdo_arbiter.sv
`timescale 1ns/1ps
module tb_dtc_ddl_rdo_arbiter;
    localparam int NCH = 20, AW = 10, DW = 33, DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, evt_rdy, ddl_xoff;
    logic [NCH-1:0]    dtc_event_rdy, ram_enb;
    logic [AW-1:0]     ram_addrb;
    logic [NCH*DW-1:0] ram_doutb = '0;
    logic              ram_read_confirm, ddl_valid, ddl_eoe, trunc_err;
    logic [31:0]       ddl_data;

    dtc_ddl_rdo_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n), .evt_rdy_i(evt_rdy),
        .dtc_event_rdy_i(dtc_event_rdy), .ram_enb_o(ram_enb), .ram_addrb_o(ram_addrb),
        .ram_doutb_i(ram_doutb), .ram_read_confirm_o(ram_read_confirm),
        .ddl_xoff_i(ddl_xoff), .ddl_data_o(ddl_data), .ddl_valid_o(ddl_valid),
        .ddl_eoe_o(ddl_eoe), .trunc_err_o(trunc_err)
    );

    logic [DW-1:0] mem [NCH][DEPTH];
    logic [32:0]   got_q[$];
    logic [32:0]   exp_q[$];
    int            checks = 0, errors = 0, confirm_cnt = 0, onehot_err = 0;
    bit            exp_trunc = 1'b0;
    logic          xo_enb;
    logic [AW-1:0] xo_addr3, xo_addr4;

    // Channel RAMs: 1-cycle registered read on port B
    always @(posedge clk)
        for (int k = 0; k < NCH; k++)
            if (ram_enb[k]) ram_doutb[k*DW +: DW] <= mem[k][ram_addrb];

    // Observers: accepted words, confirm cycles, one-hot enables
    always @(negedge clk) begin
        if (ddl_valid && !ddl_xoff) got_q.push_back({ddl_eoe, ddl_data});
        if (ram_read_confirm) confirm_cnt++;
        if (!$onehot0(ram_enb)) onehot_err++;
    end

    task automatic fill_chan(input int ch, input int len);
        for (int a = 0; a < DEPTH; a++) mem[ch][a] = {1'b0, $urandom()};
        if (len > 0) mem[ch][len-1] = {1'b1, mem[ch][len-1][31:0]};
    endtask

    // Reference: each ready channel in index order gives a header and its words up to
    // and including the end flag (or the last address); the final word carries eoe.
    task automatic build_exp(input logic [NCH-1:0] mask);
        logic [32:0] w;
        exp_q.delete();
        if (mask == '0) exp_q.push_back({1'b1, 32'hDC5A001F});
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                exp_q.push_back({1'b0, 16'hDC5A, 11'd0, 5'(c)});
                for (int a = 0; a < DEPTH; a++) begin
                    exp_q.push_back({1'b0, mem[c][a][31:0]});
                    if (mem[c][a][32]) break;
                    if (a == DEPTH-1) exp_trunc = 1'b1;
                end
            end
        end
        if (mask != '0) begin
            w = exp_q.pop_back();
            w[32] = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [32:0] got_at(input int i);
        return (i >= 0 && i < got_q.size()) ? got_q[i] : 33'h0;
    endfunction

    function automatic logic [32:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 33'h0;
    endfunction

    // mode 0: xoff low; mode 1: random xoff and mask scrambled after SCAN; mode 2: 5-cycle xoff window
    task automatic run_event(input logic [NCH-1:0] mask, input int mode, output bit to);
        int xw;
        bit done;
        got_q.delete();
        xw = -1; done = 1'b0; to = 1'b1;
        dtc_event_rdy = mask;
        evt_rdy = 1'b1;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(posedge clk); #1;
            ddl_xoff = 1'b0;
            if (mode == 1) begin
                ddl_xoff = ($urandom_range(0, 2) == 0);
                if (cyc >= 2) dtc_event_rdy = NCH'($urandom());
            end
            if (mode == 2) begin
                if (xw < 0 && got_q.size() >= 2) xw = 0;
                if (xw >= 0 && xw < 5) begin
                    ddl_xoff = 1'b1;
                    if (xw == 3) begin xo_enb = |ram_enb; xo_addr3 = ram_addrb; end
                    if (xw == 4) begin xo_enb = xo_enb | (|ram_enb); xo_addr4 = ram_addrb; end
                    xw++;
                end
            end
            if (ram_read_confirm) begin
                evt_rdy = 1'b0; ddl_xoff = 1'b0; done = 1'b1; to = 1'b0;
            end
        end
        evt_rdy = 1'b0;
        ddl_xoff = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; evt_rdy = 1'b0; ddl_xoff = 1'b0; dtc_event_rdy = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ram_enb, ram_addrb, ram_read_confirm, ddl_data, ddl_valid, ddl_eoe, trunc_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: enb=%h addr=%h conf=%b data=%h vld=%b eoe=%b trunc=%b, all required 0",
                     ram_enb, ram_addrb, ram_read_confirm, ddl_data, ddl_valid, ddl_eoe, trunc_err);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_two_channels();
        bit to; int c0, bad;
        fill_chan(3, 3); fill_chan(7, 1);
        build_exp(NCH'(1 << 3) | NCH'(1 << 7));
        c0 = confirm_cnt;
        run_event(NCH'(1 << 3) | NCH'(1 << 7), 0, to);
        checks++; if (to) begin errors++; $display("FAIL t1_timeout: confirm not seen"); end
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL t1_stream: word %0d got %h (%0d words) want %h (%0d words)",
                     bad, got_at(bad), got_q.size(), exp_at(bad), exp_q.size());
        end
        checks++;
        if (confirm_cnt - c0 != 1) begin errors++; $display("FAIL t1_confirm: %0d cycles, want 1", confirm_cnt - c0); end
        checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL t1_trunc: got %b want 0", trunc_err); end
    endtask

    task automatic test_xoff_window();
        bit to; int c0, bad;
        xo_enb = 1'bx; xo_addr3 = 'x; xo_addr4 = 'x;
        build_exp(NCH'(1 << 3) | NCH'(1 << 7));
        c0 = confirm_cnt;
        run_event(NCH'(1 << 3) | NCH'(1 << 7), 2, to);
        checks++; if (to) begin errors++; $display("FAIL t2_timeout: confirm not seen"); end
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL t2_stream: word %0d got %h (%0d words) want %h (%0d words)",
                     bad, got_at(bad), got_q.size(), exp_at(bad), exp_q.size());
        end
        checks++;
        if (xo_enb !== 1'b0) begin errors++; $display("FAIL t2_enb_stalled: enb seen=%b want 0", xo_enb); end
        checks++;
        if (xo_addr3 !== xo_addr4) begin errors++; $display("FAIL t2_addr_frozen: %h then %h", xo_addr3, xo_addr4); end
        checks++;
        if (confirm_cnt - c0 != 1) begin errors++; $display("FAIL t2_confirm: %0d cycles, want 1", confirm_cnt - c0); end
    endtask

    task automatic test_empty_event();
        bit to; int c0, bad;
        build_exp('0);
        c0 = confirm_cnt;
        run_event('0, 0, to);
        checks++; if (to) begin errors++; $display("FAIL t3_timeout: confirm not seen"); end
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL t3_stream: word %0d got %h (%0d words) want %h (%0d words)",
                     bad, got_at(bad), got_q.size(), exp_at(bad), exp_q.size());
        end
        checks++;
        if (confirm_cnt - c0 != 1) begin errors++; $display("FAIL t3_confirm: %0d cycles, want 1", confirm_cnt - c0); end
    endtask

    task automatic test_truncation();
        bit to; int c0, bad;
        fill_chan(0, 0);
        build_exp(NCH'(1));
        c0 = confirm_cnt;
        run_event(NCH'(1), 0, to);
        checks++; if (to) begin errors++; $display("FAIL t4_timeout: confirm not seen"); end
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL t4_stream: word %0d got %h (%0d words) want %h (%0d words)",
                     bad, got_at(bad), got_q.size(), exp_at(bad), exp_q.size());
        end
        checks++; if (trunc_err !== exp_trunc) begin errors++; $display("FAIL t4_trunc: got %b want %b", trunc_err, exp_trunc); end
        checks++;
        if (confirm_cnt - c0 != 1) begin errors++; $display("FAIL t4_confirm: %0d cycles, want 1", confirm_cnt - c0); end
        fill_chan(1, 2);
        build_exp(NCH'(2));
        run_event(NCH'(2), 0, to);
        bad = first_diff();
        checks++; if (to || bad != -1) begin errors++; $display("FAIL t4_next_event: timeout=%b first bad word %0d", to, bad); end
        checks++; if (trunc_err !== 1'b1) begin errors++; $display("FAIL t4_trunc_sticky: got %b want 1", trunc_err); end
    endtask

    task automatic test_reset_mid_event();
        bit to, seen; int c0, bad;
        fill_chan(5, 300);
        c0 = confirm_cnt;
        seen = 1'b0;
        dtc_event_rdy = NCH'(1 << 5);
        evt_rdy = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (ram_enb[5] && ram_addrb > 10'd5) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL t5_read_start: channel 5 read not observed"); end
        reset_n = 1'b0; evt_rdy = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ram_enb, ram_addrb, ram_read_confirm, ddl_data, ddl_valid, ddl_eoe, trunc_err} !== '0) begin
            errors++;
            $display("FAIL t5_reset_outputs: enb=%h addr=%h conf=%b data=%h vld=%b eoe=%b trunc=%b, all required 0",
                     ram_enb, ram_addrb, ram_read_confirm, ddl_data, ddl_valid, ddl_eoe, trunc_err);
        end
        exp_trunc = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        got_q.delete();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0 || confirm_cnt != c0) begin
            errors++;
            $display("FAIL t5_quiet: words=%0d confirms=%0d after reset, want 0 and 0", got_q.size(), confirm_cnt - c0);
        end
        fill_chan(0, 4); fill_chan(2, 2);
        build_exp(NCH'(5));
        run_event(NCH'(5), 0, to);
        bad = first_diff();
        checks++;
        if (to || bad != -1) begin
            errors++;
            $display("FAIL t5_clean_event: timeout=%b word %0d got %h want %h", to, bad, got_at(bad), exp_at(bad));
        end
        checks++;
        if (confirm_cnt - c0 != 1) begin errors++; $display("FAIL t5_confirm: %0d cycles, want 1", confirm_cnt - c0); end
    endtask

    task automatic test_all_channels();
        bit to; int bad, eoes;
        for (int c = 0; c < NCH; c++) fill_chan(c, 1);
        build_exp('1);
        run_event('1, 0, to);
        checks++; if (to) begin errors++; $display("FAIL t6_timeout: confirm not seen"); end
        bad = first_diff();
        checks++;
        if (bad != -1) begin
            errors++;
            $display("FAIL t6_stream: word %0d got %h (%0d words) want %h (%0d words)",
                     bad, got_at(bad), got_q.size(), exp_at(bad), exp_q.size());
        end
        eoes = 0;
        foreach (got_q[i]) if (got_q[i][32]) eoes++;
        checks++;
        if (got_q.size() != 40 || eoes != 1) begin
            errors++;
            $display("FAIL t6_shape: %0d words %0d eoe, want 40 words 1 eoe", got_q.size(), eoes);
        end
        checks++; if (onehot_err != 0) begin errors++; $display("FAIL t6_onehot: %0d multi-hot cycles, want 0", onehot_err); end
    endtask

    task automatic test_random_events();
        bit to; int c0, bad;
        logic [NCH-1:0] mask;
        for (int n = 0; n < 10; n++) begin
            mask = ($urandom_range(0, 4) == 0) ? '0 : NCH'($urandom());
            for (int c = 0; c < NCH; c++) if (mask[c]) fill_chan(c, $urandom_range(1, 6));
            build_exp(mask);
            c0 = confirm_cnt;
            run_event(mask, 1, to);
            bad = first_diff();
            checks++;
            if (to || bad != -1) begin
                errors++;
                $display("FAIL rnd%0d_stream: mask=%h timeout=%b word %0d got %h want %h",
                         n, mask, to, bad, got_at(bad), exp_at(bad));
            end
            checks++;
            if (confirm_cnt - c0 != 1) begin errors++; $display("FAIL rnd%0d_confirm: %0d cycles, want 1", n, confirm_cnt - c0); end
        end
        checks++; if (trunc_err !== exp_trunc) begin errors++; $display("FAIL rnd_trunc: got %b want %b", trunc_err, exp_trunc); end
        checks++; if (onehot_err != 0) begin errors++; $display("FAIL rnd_onehot: %0d multi-hot cycles, want 0", onehot_err); end
    endtask

    initial begin
        test_reset();
        test_two_channels();
        test_xoff_window();
        test_empty_event();
        test_truncation();
        test_reset_mid_event();
        test_all_channels();
        test_random_events();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
